sp_ram_banked: RTL and testbench

Parametrised, word-interleaved single-port SRAM subsystem. It builds one DATA_WIDTH-wide memory out of NUM_BANKS banks of byte-wide macros and replaces the fixed 16×2048×8 RAM wrapper in the core's instruction and data memory path. It adds a req/gnt/rvalid handshake, a registered read-return mux aligned to macro latency, and an optional post-reset zero-fill sequencer.

---
 rtl/sp_ram_pkg.sv | 26 ++
 rtl/sp_ram_banked_if.sv | 28 ++
 rtl/sp_ram_bank_lane.sv | 41 ++++
 rtl/sp_ram_banked.sv | 166 ++++++++++++++++
 tb/tb_sp_ram_banked.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sp_ram_pkg.sv
// sp_ram_pkg: shared types, defaults and sizing helpers for the banked SRAM.
//   init_state_e : CLEAR / READY states of the optional zero-fill sequencer
//   bank_depth() : rows per bank = RAM_SIZE / (NUM_BANKS * bytes per word)
//   bsel_w()     : bank-select width, never narrower than one bit
package sp_ram_pkg;

  localparam int unsigned DEF_RAM_SIZE   = 32768;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_NUM_BANKS  = 4;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } init_state_e;

  function automatic int unsigned bank_depth(input int unsigned ram_size,
                                             input int unsigned num_banks,
                                             input int unsigned data_width);
    return ram_size / (num_banks * (data_width / 8));
  endfunction

  function automatic int unsigned bsel_w(input int unsigned num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/sp_ram_banked_if.sv
// sp_ram_banked_if: req/gnt/rvalid memory port.
//   master drives : req_i, addr_i, we_i, be_i, wdata_i
//   slave drives  : gnt_o, rvalid_o, rdata_o, init_done_o
// Signal names are written from the memory's point of view (_i into it).
interface sp_ram_banked_if #(
  parameter int unsigned ADDR_WIDTH = $clog2(sp_ram_pkg::DEF_RAM_SIZE),
  parameter int unsigned DATA_WIDTH = sp_ram_pkg::DEF_DATA_WIDTH
);
  logic                    req_i;
  logic                    gnt_o;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic                    we_i;
  logic [DATA_WIDTH/8-1:0] be_i;
  logic [DATA_WIDTH-1:0]   wdata_i;
  logic                    rvalid_o;
  logic [DATA_WIDTH-1:0]   rdata_o;
  logic                    init_done_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, init_done_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, init_done_o
  );
endinterface

// File: rtl/sp_ram_bank_lane.sv
// sp_ram_bank_lane: one word-wide bank built from BYTES byte macros.
//   clk      : rising-edge clock
//   i_cs     : per-lane chip select
//   i_we     : shared write enable (1 = write selected lanes)
//   i_row    : shared row address
//   i_wdata  : write data, lane k on bits [8k+7:8k]
//   o_rdata  : concatenated macro outputs, valid the cycle after a read
// A macro output only updates on a selected read, so it holds otherwise.
module sp_ram_bank_lane
  import sp_ram_pkg::*;
#(
  parameter int unsigned BYTES = DEF_DATA_WIDTH / 8,
  parameter int unsigned DEPTH = bank_depth(DEF_RAM_SIZE, DEF_NUM_BANKS, DEF_DATA_WIDTH),
  parameter int unsigned ROW_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic [BYTES-1:0]   i_cs,
  input  logic               i_we,
  input  logic [ROW_W-1:0]   i_row,
  input  logic [8*BYTES-1:0] i_wdata,
  output logic [8*BYTES-1:0] o_rdata
);

  for (genvar k = 0; k < BYTES; k++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    always_ff @(posedge clk) begin
      if (i_cs[k]) begin
        if (i_we) begin
          r_mem[i_row] <= i_wdata[8*k +: 8];
        end else begin
          r_q <= r_mem[i_row];
        end
      end
    end

    assign o_rdata[8*k +: 8] = r_q;
  end

endmodule

// File: rtl/sp_ram_banked.sv
// sp_ram_banked: word-interleaved single-port SRAM made of NUM_BANKS banks.
//   clk    : rising-edge clock
//   rst_i  : synchronous active-high reset
//   bus    : sp_ram_banked_if.slave (req/gnt/addr/we/be/wdata in,
//            rvalid/rdata/init_done out)
// Address: [OFF_W-1:0] ignored, next bits select the bank, upper bits the row.
// Responses arrive the cycle after the grant; the read mux is steered by the
// bank select registered at grant time, not by the current address.
// Optional macro SP_RAM_INIT_CLEAR_EN builds a zero-fill sequencer that runs
// after every reset; without it the memory is ready one cycle after reset.
//
//   state | meaning
//   ------+------------------------------------------------------
//   CLEAR | zero-filling row r_row in every bank, no grants
//   READY | normal traffic, stays here until the next reset
module sp_ram_banked
  import sp_ram_pkg::*;
#(
  parameter int unsigned RAM_SIZE   = DEF_RAM_SIZE,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_BANKS  = DEF_NUM_BANKS,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE)
) (
  input  logic           clk,
  input  logic           rst_i,
  sp_ram_banked_if.slave bus
);

  localparam int unsigned BYTES      = DATA_WIDTH / 8;
  localparam int unsigned BANK_DEPTH = bank_depth(RAM_SIZE, NUM_BANKS, DATA_WIDTH);
  localparam int unsigned BSEL_W     = bsel_w(NUM_BANKS);
  localparam int unsigned OFF_W      = $clog2(BYTES);
  localparam int unsigned ROW_W      = $clog2(BANK_DEPTH);
  localparam int unsigned ROW_LSB    = OFF_W + $clog2(NUM_BANKS);

  logic                  w_accept;
  logic [BSEL_W-1:0]     w_bsel;
  logic [ROW_W-1:0]      w_req_row;
  logic                  w_clear;
  logic [ROW_W-1:0]      w_clr_row;
  logic                  w_init_done;
  logic [BYTES-1:0]      w_bank_cs [NUM_BANKS];
  logic [ROW_W-1:0]      w_row;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_bank_q  [NUM_BANKS];

  logic                  r_rvalid;
  logic                  r_rsp_rd;
  logic [BSEL_W-1:0]     r_bsel;

  // request decode
  assign bus.gnt_o = w_init_done & ~rst_i;
  assign w_accept  = bus.req_i & bus.gnt_o;
  assign w_req_row = bus.addr_i[ROW_LSB +: ROW_W];

  if (NUM_BANKS > 1) begin : g_bsel
    assign w_bsel = bus.addr_i[OFF_W +: BSEL_W];
  end else begin : g_bsel_single
    assign w_bsel = '0;
  end

  if (OFF_W > 0) begin : g_off
    logic w_unused_off;
    assign w_unused_off = ^bus.addr_i[OFF_W-1:0];
  end

`ifdef SP_RAM_INIT_CLEAR_EN
  init_state_e      r_state;
  init_state_e      w_state_nxt;
  logic [ROW_W-1:0] r_row;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state <= CLEAR;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) begin
        r_row <= r_row + ROW_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == CLEAR && r_row == ROW_W'(BANK_DEPTH - 1)) begin
      w_state_nxt = READY;
    end
  end

  always_comb begin
    w_clear     = (r_state == CLEAR);
    w_init_done = (r_state == READY);
  end

  assign w_clr_row = r_row;
`else
  logic r_init_done;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= 1'b1;
    end
  end

  assign w_clear     = 1'b0;
  assign w_clr_row   = '0;
  assign w_init_done = r_init_done;
`endif

  // Clear and granted traffic never overlap (no grant outside READY), so the
  // shared row/data/we path can simply be muxed on w_clear.
  assign w_row   = w_clear ? w_clr_row : w_req_row;
  assign w_we    = w_clear | bus.we_i;
  assign w_wdata = w_clear ? '0 : bus.wdata_i;

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bank_cs[b] = '0;
      if (w_clear) begin
        w_bank_cs[b] = '1;
      end else if (w_accept && w_bsel == BSEL_W'(b)) begin
        w_bank_cs[b] = bus.we_i ? bus.be_i : '1;
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sp_ram_bank_lane #(
      .BYTES (BYTES),
      .DEPTH (BANK_DEPTH),
      .ROW_W (ROW_W)
    ) u_bank (
      .clk     (clk),
      .i_cs    (w_bank_cs[b]),
      .i_we    (w_we),
      .i_row   (w_row),
      .i_wdata (w_wdata),
      .o_rdata (w_bank_q[b])
    );
  end

  // Response tracking. r_rsp_rd only changes on a grant, so rdata_o holds
  // its value until the next response (macro outputs only move on reads).
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rsp_rd <= 1'b0;
      r_bsel   <= '0;
    end else begin
      r_rvalid <= w_accept;
      if (w_accept) begin
        r_rsp_rd <= ~bus.we_i;
        r_bsel   <= w_bsel;
      end
    end
  end

  assign bus.rvalid_o    = r_rvalid;
  assign bus.rdata_o     = r_rsp_rd ? w_bank_q[r_bsel] : '0;
  assign bus.init_done_o = w_init_done;

endmodule

// File: tb/tb_sp_ram_banked.sv
module tb_sp_ram_banked;

`ifdef SP_RAM_INIT_CLEAR_EN
  localparam int LAT1 = 32768 / (4 * 4);
  localparam int LAT2 = 65536 / (8 * 8);
`else
  localparam int LAT1 = 1;
  localparam int LAT2 = 1;
`endif

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic rst2 = 1'b1;

  always #5 clk = ~clk;

  sp_ram_banked_if #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) bus1 ();
  sp_ram_banked_if #(.ADDR_WIDTH(16), .DATA_WIDTH(64)) bus2 ();

  sp_ram_banked u_dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus1)
  );

  sp_ram_banked #(
    .RAM_SIZE   (65536),
    .DATA_WIDTH (64),
    .NUM_BANKS  (8)
  ) u_dut8 (
    .clk   (clk),
    .rst_i (rst2),
    .bus   (bus2)
  );

  int n_cmp = 0;
  int n_err = 0;

  // byte-addressed reference memory; missing bytes are unknown unless cleared
  logic [7:0]  mdl [int];
  bit          zero_known = 1'b0;
  bit          ready = 1'b0;
  bit          pend_valid = 1'b0;
  bit          pend_we = 1'b0;
  logic [31:0] pend_exp = '0;
  logic [31:0] pend_mask = '0;
  logic [31:0] last_exp = '0;
  logic [31:0] last_mask = '1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mdl_read(input int a, output logic [31:0] d, output logic [31:0] m);
    int w;
    w = a & ~3;
    d = '0;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      if (mdl.exists(w + k)) begin
        d[8*k +: 8] = mdl[w + k];
        m[8*k +: 8] = 8'hFF;
      end else if (zero_known) begin
        m[8*k +: 8] = 8'hFF;
      end
    end
  endtask

  task automatic mdl_write(input int a, input logic [3:0] be, input logic [31:0] d);
    for (int k = 0; k < 4; k++) begin
      if (be[k]) mdl[(a & ~3) + k] = d[8*k +: 8];
    end
  endtask

  task automatic check_rsp();
    chk("rvalid", bus1.rvalid_o, pend_valid);
    if (pend_valid) begin
      last_exp  = pend_exp;
      last_mask = pend_mask;
    end
    if (last_mask != 0)
      chk(pend_valid ? (pend_we ? "wr_rdata" : "rd_rdata") : "rdata_hold",
          bus1.rdata_o & last_mask, last_exp & last_mask);
  endtask

  task automatic tick(input bit req, input bit we, input int addr,
                      input logic [3:0] be, input logic [31:0] wd);
    @(negedge clk);
    check_rsp();
    bus1.req_i   = req;
    bus1.we_i    = we;
    bus1.addr_i  = addr[14:0];
    bus1.be_i    = be;
    bus1.wdata_i = wd;
    #1;
    chk("gnt", bus1.gnt_o, ready);
    pend_valid = req && ready;
    pend_we    = we;
    if (pend_valid) begin
      if (we) begin
        pend_exp  = '0;
        pend_mask = '1;
        mdl_write(addr, be, wd);
      end else begin
        mdl_read(addr, pend_exp, pend_mask);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    check_rsp();
    rst_i        = 1'b1;
    bus1.req_i   = 1'b1;
    bus1.we_i    = 1'b0;
    bus1.addr_i  = '0;
    ready        = 1'b0;
    pend_valid   = 1'b0;
    @(negedge clk);
    chk("rst_gnt", bus1.gnt_o, 0);
    chk("rst_rvalid", bus1.rvalid_o, 0);
    chk("rst_rdata", bus1.rdata_o, 0);
    chk("rst_init_done", bus1.init_done_o, 0);
    rst_i     = 1'b0;
    last_exp  = '0;
    last_mask = '1;
`ifdef SP_RAM_INIT_CLEAR_EN
    mdl.delete();
    zero_known = 1'b1;
`endif
  endtask

  // req_i stays high while waiting: nothing may be granted before init_done
  task automatic wait_init(input int ncyc);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      chk("init_rvalid", bus1.rvalid_o, 0);
      chk("init_done", bus1.init_done_o, k >= LAT1);
      chk("init_gnt", bus1.gnt_o, k >= LAT1);
      if (k >= LAT1) begin
        bus1.req_i = 1'b0;
        ready = 1'b1;
        break;
      end
    end
  endtask

  task automatic t2(input bit we, input int addr, input logic [7:0] be,
                    input logic [63:0] wd, input logic [63:0] exp);
    @(negedge clk);
    bus2.req_i   = 1'b1;
    bus2.we_i    = we;
    bus2.addr_i  = addr[15:0];
    bus2.be_i    = be;
    bus2.wdata_i = wd;
    #1;
    chk("b8_gnt", bus2.gnt_o, 1);
    @(negedge clk);
    bus2.req_i = 1'b0;
    chk("b8_rvalid", bus2.rvalid_o, 1);
    chk("b8_rdata", bus2.rdata_o, we ? 64'h0 : exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    bus1.req_i = 0; bus1.we_i = 0; bus1.addr_i = '0; bus1.be_i = '0; bus1.wdata_i = '0;
    bus2.req_i = 0; bus2.we_i = 0; bus2.addr_i = '0; bus2.be_i = '0; bus2.wdata_i = '0;

    // power-up reset and init latency
    apply_reset();
    wait_init(LAT1);

    // first/last word (zero when cleared)
    tick(1, 0, 'h0000, 4'h0, 32'h0);
    tick(1, 0, 'h7FFC, 4'h0, 32'h0);

    // write then read-after-write
    tick(1, 1, 'h0004, 4'hF, 32'hDEADBEEF);
    tick(1, 0, 'h0004, 4'h0, 32'h0);

    // partial byte enables, and be=0 write
    tick(1, 1, 'h0010, 4'hF, 32'h11223344);
    tick(1, 1, 'h0010, 4'b0101, 32'hAABBCCDD);
    tick(1, 0, 'h0010, 4'h0, 32'h0);
    tick(1, 1, 'h0010, 4'h0, 32'hFFFFFFFF);
    tick(1, 0, 'h0010, 4'h0, 32'h0);

    // one value per bank, then back-to-back alternating reads
    tick(1, 1, 'h0000, 4'hF, 32'hA0A0A0A0);
    tick(1, 1, 'h0004, 4'hF, 32'hB1B1B1B1);
    tick(1, 1, 'h0008, 4'hF, 32'hC2C2C2C2);
    tick(1, 1, 'h000C, 4'hF, 32'hD3D3D3D3);
    tick(1, 0, 'h0000, 4'h0, 32'h0);
    tick(1, 0, 'h0004, 4'h0, 32'h0);
    tick(1, 0, 'h0008, 4'h0, 32'h0);
    tick(1, 0, 'h000C, 4'h0, 32'h0);
    tick(1, 0, 'h0008, 4'h0, 32'h0);
    tick(1, 0, 'h0001, 4'h0, 32'h0);
    tick(1, 0, 'h000E, 4'h0, 32'h0);
    tick(0, 0, 'h0004, 4'h0, 32'h0);
    tick(0, 1, 'h0008, 4'hF, 32'h0);

    // randomized traffic over two row windows
    for (int i = 0; i < 400; i++) begin
      a = (($urandom_range(0, 1) != 0) ? 'h7F00 : 0)
          + int'($urandom_range(0, 63)) * 4 + int'($urandom_range(0, 3));
      tick($urandom_range(0, 9) < 8, $urandom_range(0, 1) != 0, a,
           4'($urandom_range(0, 15)), $urandom);
    end

`ifdef SP_RAM_INIT_CLEAR_EN
    // reset partway through a clear restarts it from row 0
    apply_reset();
    wait_init(1000);
    apply_reset();
    wait_init(LAT1);
    for (int i = 0; i < 16; i++) tick(1, 0, i * 4, 4'h0, 32'h0);
    for (int i = 0; i < 8; i++) tick(1, 0, 'h7F00 + i * 4, 4'h0, 32'h0);
`endif

    // reset with a read response pending
    tick(1, 1, 'h0020, 4'hF, 32'h5A5A1234);
    tick(1, 0, 'h0020, 4'h0, 32'h0);
    apply_reset();
    wait_init(LAT1);
    for (int i = 0; i < 12; i++) tick(1, 0, i * 4, 4'h0, 32'h0);
    tick(1, 0, 'h0020, 4'h0, 32'h0);
    tick(0, 0, 0, 4'h0, 32'h0);
    tick(0, 0, 0, 4'h0, 32'h0);

    // 8-bank, 64-bit configuration
    @(negedge clk);
    rst2 = 1'b0;
    for (int k = 1; k <= LAT2; k++) begin
      @(negedge clk);
      chk("b8_init_done", bus2.init_done_o, k >= LAT2);
      if (k >= LAT2) break;
    end
    t2(1, 'h0038, 8'hFF, 64'h0123456789ABCDEF, 64'h0);
    t2(1, 'h0040, 8'hFF, 64'hFEDCBA9876543210, 64'h0);
    t2(1, 'h0000, 8'hFF, 64'h5555AAAA5555AAAA, 64'h0);
    t2(1, 'h0078, 8'hFF, 64'h7777000077770000, 64'h0);
    t2(0, 'h0038, 8'h00, 64'h0, 64'h0123456789ABCDEF);
    t2(0, 'h0040, 8'h00, 64'h0, 64'hFEDCBA9876543210);
    t2(0, 'h0000, 8'h00, 64'h0, 64'h5555AAAA5555AAAA);
    t2(0, 'h0078, 8'h00, 64'h0, 64'h7777000077770000);
    t2(1, 'h0038, 8'h0F, 64'hFFFFFFFFFFFFFFFF, 64'h0);
    t2(0, 'h003C, 8'h00, 64'h0, 64'h01234567FFFFFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
